// File: rtl/gray_window_3x3_pkg.sv
// Shared definitions for the 3x3 grayscale window generator and the
// filter stages (Sobel, Gaussian, ...) that consume its window bus.
package gray_window_3x3_pkg;

   localparam int PIX_W    = 8;
   localparam int WIN_TAPS = 9;
   localparam int WIN_W    = PIX_W * WIN_TAPS;

   // Bit offset of tap w[r][c] on the flattened window bus.
   // r=0 is the oldest line, c=0 is the oldest column.
   function automatic int win_off(input int r, input int c);
      return PIX_W * (3 * r + c);
   endfunction

endpackage

// File: rtl/gray_window_3x3_line_buffer.sv
// Single-port line memory, one pixel per column. The read port is
// combinational, so a read and a write to the same column in one cycle
// returns the old contents (read-before-write). Contents are not reset.
module line_buffer
   import gray_window_3x3_pkg::*;
#(
   parameter int DEPTH = 640,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [PIX_W-1:0] wr_data,
   output logic [PIX_W-1:0] rd_data
);

   logic [PIX_W-1:0] mem [0:DEPTH-1];

   assign rd_data = mem[addr];

   // Store the incoming pixel at the addressed column.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wr_data;
      end
   end

endmodule

// File: rtl/gray_window_3x3.sv
// Builds a sliding 3x3 window over a raster-order grayscale stream using
// two line buffers and a 3x3 shift register. Only windows that lie fully
// inside the image are flagged valid, so no border padding is produced.
module gray_window_3x3
   import gray_window_3x3_pkg::*;
#(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   input  logic             sof,
   output logic [WIN_W-1:0] win_out,
   output logic             win_valid,
   output logic             frame_done
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);

   logic [1:0]       rst_sync;
   logic             rst_int_n;
   logic [CW-1:0]    col;
   logic [RW-1:0]    row;
   logic [CW-1:0]    eff_col;
   logic [RW-1:0]    eff_row;
   logic [PIX_W-1:0] line0_rd;
   logic [PIX_W-1:0] line1_rd;
   logic [WIN_W-1:0] win_q;

   // Reset asserts immediately but releases only after two clean clock edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync[1];

   // A start-of-frame pixel is treated as (0,0) whatever the counters say.
   assign eff_col = sof ? '0 : col;
   assign eff_row = sof ? '0 : row;

   // Raster position of the next pixel; advances only on accepted pixels.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         col <= '0;
         row <= '0;
      end else if (pix_valid) begin
         if (eff_col == COL_LAST) begin
            col <= '0;
            row <= (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
         end else begin
            col <= eff_col + 1'b1;
            row <= eff_row;
         end
      end
   end

   line_buffer #(.DEPTH(IMG_WIDTH)) u_line0 (
      .clk     (clk),
      .we      (pix_valid),
      .addr    (eff_col),
      .wr_data (pix_in),
      .rd_data (line0_rd)
   );

   line_buffer #(.DEPTH(IMG_WIDTH)) u_line1 (
      .clk     (clk),
      .we      (pix_valid),
      .addr    (eff_col),
      .wr_data (line0_rd),
      .rd_data (line1_rd)
   );

   // Shift the window left one column and load the new right-hand column.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         win_q <= '0;
      end else if (pix_valid) begin
         for (int r = 0; r < 3; r++) begin
            win_q[win_off(r, 0) +: PIX_W] <= win_q[win_off(r, 1) +: PIX_W];
            win_q[win_off(r, 1) +: PIX_W] <= win_q[win_off(r, 2) +: PIX_W];
         end
         win_q[win_off(0, 2) +: PIX_W] <= line1_rd;
         win_q[win_off(1, 2) +: PIX_W] <= line0_rd;
         win_q[win_off(2, 2) +: PIX_W] <= pix_in;
      end
   end

   // Flag complete windows and the final window of each frame.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         win_valid  <= pix_valid && (eff_row >= ROW_TWO) && (eff_col >= COL_TWO);
         frame_done <= pix_valid && (eff_row == ROW_LAST) && (eff_col == COL_LAST);
      end
   end

   assign win_out = win_q;

endmodule

// File: tb/tb_gray_window_3x3.sv
// Directed bench for gray_window_3x3 on a 4x4 image. Pixel value is
// base + 16*row + col; expected windows come from the bench's own copy
// of the image it sent.
module tb_gray_window_3x3;

   logic        clk;
   logic        rst_n;
   logic [7:0]  pix_in;
   logic        pix_valid;
   logic        sof;
   logic [71:0] win_out;
   logic        win_valid;
   logic        frame_done;

   int checks;
   int passes;
   int fails;

   logic [7:0]  img [4][4];
   logic [71:0] last_exp_win;
   logic        hold_known;
   int          frame_valid_cnt;
   int          frame_done_cnt;
   logic [71:0] first_obs_win;
   logic [71:0] last_obs_win;

   gray_window_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .sof        (sof),
      .win_out    (win_out),
      .win_valid  (win_valid),
      .frame_done (frame_done)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, then sample just after the clock edge.
   task automatic applyStimulus(input logic v, input logic s, input logic [7:0] p,
                                input logic exp_v, input logic exp_fd,
                                input logic [71:0] exp_w, input logic chk_w);
      pix_valid = v;
      sof       = s;
      pix_in    = p;
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      sof       = 1'b0;
      checkOutput("win_valid", {71'd0, win_valid}, {71'd0, exp_v});
      checkOutput("frame_done", {71'd0, frame_done}, {71'd0, exp_fd});
      if (chk_w) checkOutput("win_out", win_out, exp_w);
      if (win_valid) begin
         if (frame_valid_cnt == 0) first_obs_win = win_out;
         last_obs_win = win_out;
         frame_valid_cnt++;
      end
      if (frame_done) frame_done_cnt++;
   endtask

   // Send the first npix pixels of a frame, sof on the first one.
   task automatic sendFrame(input logic [7:0] base, input bit toggle, input int npix);
      logic [71:0] ew;
      logic        ev;
      logic        efd;
      for (int k = 0; k < npix; k++) begin
         int r;
         int c;
         r = k / 4;
         c = k % 4;
         img[r][c] = base + 8'(16 * r + c);
         ev  = (r >= 2) && (c >= 2);
         efd = (r == 3) && (c == 3);
         ew  = '0;
         if (ev) begin
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  ew[8*(3*i+j) +: 8] = img[r-2+i][c-2+j];
         end
         applyStimulus(1'b1, k == 0, img[r][c], ev, efd, ew, ev);
         hold_known = ev;
         if (ev) last_exp_win = ew;
         if (toggle) begin
            applyStimulus(1'b0, (k % 3) == 0, 8'hEE, 1'b0, 1'b0, last_exp_win, hold_known);
         end
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, last_exp_win, hold_known);
   endtask

   task automatic clearCounts();
      frame_valid_cnt = 0;
      frame_done_cnt  = 0;
      first_obs_win   = '0;
      last_obs_win    = '0;
   endtask

   task automatic checkCounts(input string tag, input int exp_v, input int exp_fd);
      checkOutput({tag, " win_valid count"}, 72'(frame_valid_cnt), 72'(exp_v));
      checkOutput({tag, " frame_done count"}, 72'(frame_done_cnt), 72'(exp_fd));
   endtask

   // Hand-computed taps of the first and last window of a base-0 frame.
   task automatic checkBaseWindows(input string tag);
      checkOutput({tag, " first w00"}, {64'd0, first_obs_win[7:0]},   72'h00);
      checkOutput({tag, " first w11"}, {64'd0, first_obs_win[39:32]}, 72'h11);
      checkOutput({tag, " first w22"}, {64'd0, first_obs_win[71:64]}, 72'h22);
      checkOutput({tag, " last w00"},  {64'd0, last_obs_win[7:0]},    72'h11);
      checkOutput({tag, " last w22"},  {64'd0, last_obs_win[71:64]},  72'h33);
   endtask

   // Directed scenario sequence.
   initial begin
      checks       = 0;
      passes       = 0;
      fails        = 0;
      hold_known   = 1'b0;
      last_exp_win = '0;
      pix_in       = 8'h00;
      pix_valid    = 1'b0;
      sof          = 1'b0;
      rst_n        = 1'b0;
      clearCounts();

      $display("[TB] reset state");
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset win_out", win_out, 72'd0);
      checkOutput("reset win_valid", {71'd0, win_valid}, 72'd0);
      checkOutput("reset frame_done", {71'd0, frame_done}, 72'd0);
      rst_n = 1'b1;
      idleCycles(4);

      $display("[TB] continuous frame");
      clearCounts();
      sendFrame(8'h00, 1'b0, 16);
      idleCycles(2);
      checkCounts("continuous", 4, 1);
      checkBaseWindows("continuous");

      $display("[TB] toggled pix_valid frame");
      clearCounts();
      sendFrame(8'h00, 1'b1, 16);
      idleCycles(2);
      checkCounts("toggled", 4, 1);
      checkBaseWindows("toggled");

      $display("[TB] back-to-back frames");
      clearCounts();
      sendFrame(8'h00, 1'b0, 16);
      sendFrame(8'h80, 1'b0, 16);
      idleCycles(2);
      checkCounts("back-to-back", 8, 2);
      checkOutput("second frame last w00", {64'd0, last_obs_win[7:0]}, 72'h91);
      checkOutput("second frame last w22", {64'd0, last_obs_win[71:64]}, 72'hB3);

      $display("[TB] sof realign mid-frame");
      clearCounts();
      sendFrame(8'h40, 1'b0, 6);
      sendFrame(8'h00, 1'b0, 16);
      idleCycles(2);
      checkCounts("sof realign", 4, 1);
      checkBaseWindows("sof realign");

      $display("[TB] reset mid-frame");
      clearCounts();
      sendFrame(8'h00, 1'b0, 9);
      rst_n = 1'b0;
      #1;
      checkOutput("mid reset win_out", win_out, 72'd0);
      checkOutput("mid reset win_valid", {71'd0, win_valid}, 72'd0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         checkOutput("mid reset win_out held", win_out, 72'd0);
         checkOutput("mid reset frame_done", {71'd0, frame_done}, 72'd0);
      end
      rst_n      = 1'b1;
      hold_known = 1'b0;
      idleCycles(4);
      sendFrame(8'h00, 1'b0, 16);
      idleCycles(2);
      checkCounts("after reset", 4, 1);
      checkBaseWindows("after reset");

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
